// File: rtl/soft_demap.sv
// soft_demap: QPSK soft demapper feeding the received-codeword buffer.
// Each accepted I/Q sample is quantized to two 3-bit signed soft values.
// The values are emitted I-first, then Q, one per cycle, with codeword
// framing flags every DEPTH values.
//
// Ports:
//   clk     in   working clock
//   rst     in   asynchronous reset, active-low
//   iq_i    in   signed in-phase sample (IW bits)
//   iq_q    in   signed quadrature sample (IW bits)
//   iq_vld  in   input sample valid
//   iq_rdy  out  sample can be accepted this cycle (combinational from state)
//   do_o    out  soft value, 3-bit two's complement, range -3..+3
//   do_vld  out  do_o valid
//   do_sof  out  first soft value of a codeword (qualified by do_vld)
//   do_eof  out  last soft value of a codeword (qualified by do_vld)
module soft_demap #(
    parameter int unsigned IW    = 8,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] iq_i,
    input  logic [IW-1:0] iq_q,
    input  logic          iq_vld,
    output logic          iq_rdy,
    output logic [2:0]    do_o,
    output logic          do_vld,
    output logic          do_sof,
    output logic          do_eof
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_Q    = 1'b1;

    localparam logic signed [IW-1:0] SAT_HI = IW'(3);
    localparam logic signed [IW-1:0] SAT_LO = IW'(-3);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [2:0]    do_q, do_d;
    logic          vld_q, vld_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [2:0]    hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          emit;

    // Scale by arithmetic shift (floor), then saturate symmetrically to +/-3.
    function automatic logic [2:0] quant(input logic [IW-1:0] x);
        logic signed [IW-1:0] t;
        t = $signed(x) >>> SHIFT;
        if (t > SAT_HI) begin
            quant = 3'b011;
        end else if (t < SAT_LO) begin
            quant = 3'b101;
        end else begin
            quant = t[2:0];
        end
    endfunction

    // The only stall point: a Q value is still pending in the holding register.
    assign iq_rdy = (state_q == S_IDLE);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        do_d    = do_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        emit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iq_vld) begin
                    do_d    = quant(iq_i);
                    hold_d  = quant(iq_q);
                    emit    = 1'b1;
                    state_d = S_Q;
                end
            end
            S_Q: begin
                do_d    = hold_q;
                emit    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame position advances only with emitted values, so gaps keep alignment.
        if (emit) begin
            vld_d = 1'b1;
            sof_d = (cnt_q == '0);
            eof_d = (cnt_q == CNT_LAST);
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            do_q    <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            do_q    <= do_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign do_o   = do_q;
    assign do_vld = vld_q;
    assign do_sof = sof_q;
    assign do_eof = eof_q;

endmodule
